// File: rtl/cp0_intc.sv
// CP0 interrupt controller: STATUS/CAUSE/EPC, per-line sync and edge capture,
// fixed-priority arbitration (lowest index wins) and a req/ack handshake with the pipeline.
// Optional COUNT/COMPARE timer is enabled by defining CP0_TIMER_EN.
module cp0_intc #(
  parameter int unsigned NUM_IRQ       = 8,
  parameter logic [7:0]  EDGE_MASK     = 8'h00,
  parameter logic [31:0] VECTOR_BASE   = 32'h0000_0180,
  parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0020
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               cp0_wen_i,
  input  logic [4:0]         cp0_addr_i,
  input  logic [31:0]        cp0_din_i,
  output logic [31:0]        cp0_dout_o,
  output logic               irq_req_o,
  input  logic               irq_ack_i,
  input  logic [31:0]        epc_in_i,
  output logic [31:0]        irq_vector_o,
  output logic [2:0]         irq_id_o,
  input  logic               eret_i,
  output logic [31:0]        epc_out_o
);

  localparam logic [NUM_IRQ-1:0] EdgeMsk = EDGE_MASK[NUM_IRQ-1:0];

  typedef enum logic [1:0] {StIdle, StReq, StServ} state_e;

  state_e             state_q;
  logic               irq_req_q;
  logic [2:0]         irq_id_q;
  logic [NUM_IRQ-1:0] sync1_q, sync2_q, hist_q;
  logic [NUM_IRQ-1:0] ip_q, ip_d;
  logic [NUM_IRQ-1:0] im_q, im_d;
  logic               ie_q, ie_d, exl_q, exl_d;
  logic [31:0]        epc_q, epc_d;
  logic [NUM_IRQ-1:0] pend, act, w1c, rise;
  logic [7:0]         act_ext;
  logic [2:0]         win;
  logic               cond, ack_fire, eret_fire;
  logic               wr_status, wr_cause, wr_epc;

  assign wr_status = cp0_wen_i && (cp0_addr_i == 5'd12);
  assign wr_cause  = cp0_wen_i && (cp0_addr_i == 5'd13);
  assign wr_epc    = cp0_wen_i && (cp0_addr_i == 5'd14);
  assign ack_fire  = irq_ack_i & irq_req_q;
  // ERET is ignored while a request is outstanding
  assign eret_fire = eret_i & ~irq_req_q;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        ti_q, ti_d;

  // Timer next state: software writes override the free-running increment
  always_comb begin
    count_d   = (cp0_wen_i && cp0_addr_i == 5'd9) ? cp0_din_i : count_q + 32'd1;
    compare_d = (cp0_wen_i && cp0_addr_i == 5'd11) ? cp0_din_i : compare_q;
    ti_d      = (cp0_wen_i && cp0_addr_i == 5'd11) ? 1'b0 : (ti_q | (count_q == compare_q));
  end

  // Timer state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= 32'hFFFF_FFFF;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end
`endif

  // Pending lines as seen by the arbiter (timer folds into the top line)
  always_comb begin
    pend = ip_q;
`ifdef CP0_TIMER_EN
    pend[NUM_IRQ-1] = ip_q[NUM_IRQ-1] | ti_q;
`endif
  end

  assign act     = pend & im_q;
  assign act_ext = 8'(act);
  assign cond    = ie_q & ~exl_q & (|act);

  // Fixed priority: scan downwards so the lowest active index is left in win
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (act[i]) win = 3'(i);
    end
  end

  // Edge lines: sticky on synced rise, W1C; a coincident rise keeps the bit set
  always_comb begin
    rise = sync2_q & ~hist_q;
    w1c  = wr_cause ? (cp0_din_i[8 +: NUM_IRQ] & EdgeMsk) : '0;
    ip_d = (EdgeMsk & ((ip_q & ~w1c) | rise)) | (~EdgeMsk & sync2_q);
  end

  // STATUS/EPC next state: software write, then ERET, then acknowledge (ack forces EXL)
  always_comb begin
    ie_d  = wr_status ? cp0_din_i[0] : ie_q;
    exl_d = wr_status ? cp0_din_i[1] : exl_q;
    im_d  = wr_status ? cp0_din_i[8 +: NUM_IRQ] : im_q;
    epc_d = wr_epc ? cp0_din_i : epc_q;
    if (eret_fire) exl_d = 1'b0;
    if (ack_fire) begin
      exl_d = 1'b1;
      epc_d = epc_in_i;
    end
  end

  // Synchroniser, edge history, pending and CP0 register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      ip_q    <= '0;
      im_q    <= '0;
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      epc_q   <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      ip_q    <= ip_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      epc_q   <= epc_d;
    end
  end

  // Request FSM; the request is withdrawn if the held line stops being eligible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      irq_req_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cond) begin
            irq_req_q <= 1'b1;
            irq_id_q  <= win;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (ack_fire) begin
            irq_req_q <= 1'b0;
            state_q   <= StServ;
          end else if (!cond || !act_ext[irq_id_q]) begin
            irq_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StServ: begin
          if (eret_i || !exl_q) state_q <= StIdle;
        end
        default: begin
          irq_req_q <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // mfc0 read mux
  always_comb begin
    cp0_dout_o = '0;
    unique case (cp0_addr_i)
      5'd12: begin
        cp0_dout_o[0]           = ie_q;
        cp0_dout_o[1]           = exl_q;
        cp0_dout_o[8 +: NUM_IRQ] = im_q;
      end
      5'd13: begin
        cp0_dout_o[8 +: NUM_IRQ] = pend;
`ifdef CP0_TIMER_EN
        cp0_dout_o[30] = ti_q;
`endif
      end
      5'd14: cp0_dout_o = epc_q;
`ifdef CP0_TIMER_EN
      5'd9:  cp0_dout_o = count_q;
      5'd11: cp0_dout_o = compare_q;
`endif
      default: cp0_dout_o = '0;
    endcase
  end

  assign irq_req_o    = irq_req_q;
  assign irq_id_o     = irq_id_q;
  assign irq_vector_o = VECTOR_BASE + 32'(irq_id_q) * VECTOR_STRIDE;
  assign epc_out_o    = epc_q;

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: register-map vector table plus handshake sequences.
module tb_cp0_intc;

  logic        clk, rst;
  logic [7:0]  irq;
  logic        cp0_wen;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_din, cp0_dout;
  logic        irq_req, irq_ack, eret;
  logic [31:0] epc_in, irq_vector, epc_out;
  logic [2:0]  irq_id;

  int vec_n  = 0;
  int fail_n = 0;

  cp0_intc #(
    .NUM_IRQ      (8),
    .EDGE_MASK    (8'h01),
    .VECTOR_BASE  (32'h0000_0180),
    .VECTOR_STRIDE(32'h0000_0020)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_i       (irq),
    .cp0_wen_i   (cp0_wen),
    .cp0_addr_i  (cp0_addr),
    .cp0_din_i   (cp0_din),
    .cp0_dout_o  (cp0_dout),
    .irq_req_o   (irq_req),
    .irq_ack_i   (irq_ack),
    .epc_in_i    (epc_in),
    .irq_vector_o(irq_vector),
    .irq_id_o    (irq_id),
    .eret_i      (eret),
    .epc_out_o   (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] exp;
  } regvec_t;

  regvec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s: got %08h want %08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_wen  = 1'b1;
    cp0_addr = a;
    cp0_din  = d;
    tick();
    cp0_wen  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = cp0_dout;
  endtask

  logic [31:0] r;

  initial begin
    tbl[0] = '{1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0000_FF03};
    tbl[1] = '{1'b1, 5'd12, 32'h0000_0000, 32'h0000_0000};
    tbl[2] = '{1'b1, 5'd14, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[4] = '{1'b1, 5'd5,  32'h1234_5678, 32'h0000_0000};
    tbl[5] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[6] = '{1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000};
    tbl[7] = '{1'b1, 5'd14, 32'h0000_0000, 32'h0000_0000};

    rst = 1'b1; irq = '0; cp0_wen = 1'b0; cp0_addr = '0; cp0_din = '0;
    irq_ack = 1'b0; epc_in = '0; eret = 1'b0;
    #12;
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_req", 32'(irq_req), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_vector", irq_vector, 32'h0000_0180);
    check("rst_epc_out", epc_out, 32'd0);
    rd(5'd12, r); check("rst_status", r, 32'd0);
    rd(5'd13, r); check("rst_cause", r, 32'd0);

    // Register-map vectors
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wen) mtc0(tbl[i].addr, tbl[i].din);
      rd(tbl[i].addr, r);
      check($sformatf("regvec%0d", i), r, tbl[i].exp);
    end
    check("epc_out_cleared", epc_out, 32'd0);

    // Level line 3: pin high before edge 1, IP after edge 3, request after edge 4
    mtc0(5'd12, 32'h0000_0801);
    irq[3] = 1'b1;
    tick(); tick(); tick();
    rd(5'd13, r); check("l3_ip_edge3", r, 32'h0000_0800);
    check("l3_req_edge3", 32'(irq_req), 32'd0);
    tick();
    check("l3_req_edge4", 32'(irq_req), 32'd1);
    check("l3_id", 32'(irq_id), 32'd3);
    check("l3_vector", irq_vector, 32'h0000_01E0);

    // Acknowledge, then ERET
    irq_ack = 1'b1; epc_in = 32'h0000_0400;
    tick();
    irq_ack = 1'b0;
    rd(5'd14, r); check("ack_epc", r, 32'h0000_0400);
    rd(5'd12, r); check("ack_status", r, 32'h0000_0803);
    check("ack_req", 32'(irq_req), 32'd0);
    irq[3] = 1'b0;
    tick(); tick(); tick(); tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd12, r); check("eret_status", r, 32'h0000_0801);
    check("eret_epc_out", epc_out, 32'h0000_0400);
    tick();
    check("eret_no_req", 32'(irq_req), 32'd0);

    // Priority: lines 5 and 2 active, line 2 wins
    mtc0(5'd12, 32'h0000_2401);
    irq[5] = 1'b1; irq[2] = 1'b1;
    tick(); tick(); tick(); tick();
    check("pri_req", 32'(irq_req), 32'd1);
    check("pri_id", 32'(irq_id), 32'd2);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("eret_in_req_req", 32'(irq_req), 32'd1);
    check("eret_in_req_id", 32'(irq_id), 32'd2);
    // Mask line 2: request withdrawn, then re-raised for line 5
    mtc0(5'd12, 32'h0000_2001);
    check("mask_held_id", 32'(irq_id), 32'd2);
    tick();
    check("withdraw_req", 32'(irq_req), 32'd0);
    tick();
    check("reraise_req", 32'(irq_req), 32'd1);
    check("reraise_id", 32'(irq_id), 32'd5);
    check("reraise_vector", irq_vector, 32'h0000_0220);

    // Ack coincident with mtc0 EPC: epc_in wins
    irq_ack = 1'b1; epc_in = 32'h0000_0500;
    cp0_wen = 1'b1; cp0_addr = 5'd14; cp0_din = 32'h0000_0999;
    tick();
    irq_ack = 1'b0; cp0_wen = 1'b0;
    check("ack_vs_mtc0_epc", epc_out, 32'h0000_0500);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("post_eret_req0", 32'(irq_req), 32'd0);
    tick();
    check("post_eret_req1", 32'(irq_req), 32'd1);

    // Ack coincident with mtc0 STATUS: EXL forced, other bits written
    irq_ack = 1'b1; epc_in = 32'h0000_0600;
    cp0_wen = 1'b1; cp0_addr = 5'd12; cp0_din = 32'h0000_2400;
    tick();
    irq_ack = 1'b0; cp0_wen = 1'b0;
    rd(5'd12, r); check("ack_vs_mtc0_status", r, 32'h0000_2402);
    irq[5] = 1'b0; irq[2] = 1'b0;
    mtc0(5'd12, 32'h0000_0000);
    tick(); tick(); tick();

    // Edge line 0: single-cycle pulse is sticky, W1C clears it
    mtc0(5'd12, 32'h0000_0100);
    irq[0] = 1'b1;
    tick();
    irq[0] = 1'b0;
    tick(); tick();
    rd(5'd13, r); check("edge_ip_set", r, 32'h0000_0100);
    tick(); tick(); tick();
    rd(5'd13, r); check("edge_ip_sticky", r, 32'h0000_0100);
    mtc0(5'd13, 32'h0000_0100);
    rd(5'd13, r); check("edge_w1c", r, 32'h0000_0000);
    // Re-arm, then W1C on the same edge as a new rise
    irq[0] = 1'b1;
    tick();
    irq[0] = 1'b0;
    tick(); tick(); tick(); tick();
    rd(5'd13, r); check("edge_rearm", r, 32'h0000_0100);
    irq[0] = 1'b1;
    tick();
    irq[0] = 1'b0;
    tick();
    mtc0(5'd13, 32'h0000_0100);
    rd(5'd13, r); check("edge_w1c_vs_rise", r, 32'h0000_0100);
    mtc0(5'd13, 32'h0000_0100);
    tick(); tick();

    // Async reset mid-REQ takes effect without a clock edge
    mtc0(5'd12, 32'h0000_0801);
    irq[3] = 1'b1;
    tick(); tick(); tick(); tick();
    check("pre_rst_req", 32'(irq_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_req", 32'(irq_req), 32'd0);
    check("async_rst_epc", epc_out, 32'd0);
    rd(5'd12, r); check("async_rst_status", r, 32'd0);
    rd(5'd13, r); check("async_rst_cause", r, 32'd0);
    check("async_rst_vector", irq_vector, 32'h0000_0180);
    irq[3] = 1'b0;
    tick();
    rst = 1'b0;
    tick();

`ifdef CP0_TIMER_EN
    // Timer: COUNT wraps, TI set when COUNT reaches COMPARE, request on line 7
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'hFFFF_FFFE);
    mtc0(5'd11, 32'h0000_0001);
    tick();
    rd(5'd9, r); check("timer_wrap", r, 32'h0000_0000);
    tick();
    rd(5'd13, r); check("timer_ti_not_yet", r, 32'h0000_0000);
    tick();
    rd(5'd13, r); check("timer_ti_set", r, 32'h4000_8000);
    tick();
    check("timer_req", 32'(irq_req), 32'd1);
    check("timer_id", 32'(irq_id), 32'd7);
    mtc0(5'd11, 32'h0000_1000);
    rd(5'd13, r); check("timer_ti_clear", r, 32'h0000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, fail_n);
    $finish;
  end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Parametrised coprocessor-0 interrupt controller for the 5-stage MIPS core; successor to the single-line cp0 interrupt input.
- Accepts NUM_IRQ external lines, each level- or edge-sensitive. Holds STATUS/CAUSE/EPC, arbitrates by fixed priority, and runs a request/acknowledge handshake with the pipeline.
- Provides mfc0/mtc0 register access and ERET return.

Parameters:
- NUM_IRQ, 8, number of external interrupt lines (1..8)
- EDGE_MASK, 8'h00, bit i=1 makes line i edge-triggered (rising), 0 makes it level
- VECTOR_BASE, 32'h0000_0180, handler base address
- VECTOR_STRIDE, 32'h0000_0020, per-line handler offset

Ports:
- clk  in  1  main clock
- rst  in  1  asynchronous active-high reset
- irq  in  NUM_IRQ  external interrupt lines, asynchronous to clk
- cp0_wen  in  1  mtc0 write strobe
- cp0_addr  in  5  CP0 register number
- cp0_din  in  32  mtc0 write data
- cp0_dout  out  32  mfc0 read data, combinational from cp0_addr
- irq_req  out  1  interrupt request to pipeline
- irq_ack  in  1  pipeline accepts request; epc_in valid this cycle
- epc_in  in  32  PC of the first unretired instruction
- irq_vector  out  32  handler address, VECTOR_BASE + irq_id*VECTOR_STRIDE
- irq_id  out  3  winning line index
- eret  in  1  ERET executed (single-cycle pulse)
- epc_out  out  32  current EPC, the ERET target

Behaviour:
- Reset (async, rst=1) clears: STATUS, CAUSE, EPC, sync flops, edge history, irq_req, irq_id. All outputs read 0 except irq_vector, which reads VECTOR_BASE.
- Input path:
  - 2-flop synchroniser per line.
  - Level line: CAUSE.IP[i] is the registered copy of the synced level.
  - Edge line: CAUSE.IP[i] is set on a synced 0->1 transition and held until W1C.
  - Latency: irq stable high before edge 1 gives IP visible after edge 3.
- Register map:
  - 12 STATUS: [0] IE, [1] EXL, [8+NUM_IRQ-1:8] IM; other bits read 0 and are not writable.
  - 13 CAUSE: [8+NUM_IRQ-1:8] IP, read-only for level lines and W1C for edge lines. [6:2] ExcCode, read-only, 0 = Int.
  - 14 EPC: fully writable.
  - All other addresses read 0; writes to them are ignored.
- Arbitration:
  - act = IP & IM.
  - cond = IE & ~EXL & |act.
  - Lowest index wins.
- Handshake and state machine:
  - IDLE: when cond=1 at a clock edge, register irq_id (winner at that edge) and set irq_req=1; go to REQ. Pin high before edge 1 gives irq_req high after edge 4.
  - REQ: irq_req and irq_id are held stable until irq_ack.
    - If cond drops before ack (IP cleared, IE/IM written 0): deassert irq_req next edge, return to IDLE, no state change.
    - irq_ack while irq_req=1: EPC<=epc_in, EXL<=1, ExcCode<=0, irq_req<=0; go to SERV.
    - irq_ack while irq_req=0 is ignored.
  - SERV: EXL=1 blocks new requests. ERET pulse: EXL<=0; go to IDLE. A new request may assert on the following edge.
- Simultaneous events:
  - irq_ack and mtc0 STATUS in the same cycle: EXL is forced to 1, other written bits take effect.
  - irq_ack and mtc0 EPC in the same cycle: epc_in wins.
  - eret while irq_req=1: ignored.
  - W1C and a new edge on the same bit in the same cycle: bit stays set.
- epc_out = EPC register, always.

Optional Feature:
- CP0_TIMER_EN defined:
  - Adds COUNT (reg 9, +1 every cycle, wraps 0xFFFFFFFF->0, writable) and COMPARE (reg 11).
  - COUNT==COMPARE sets sticky CAUSE.TI [30] and ORs it into line NUM_IRQ-1 pending.
  - A write to COMPARE clears TI.
  - Reset: COUNT=0, COMPARE=0xFFFFFFFF.
- Undefined: regs 9/11 read 0, writes ignored, TI reads 0.

Test Plan:
- Reset: rst pulse mid-REQ -> irq_req=0, STATUS=CAUSE=EPC=0 immediately, without waiting for a clock edge.
- Level line 3: IE=1, IM=8'h08; irq[3]=1 -> irq_req after 4 edges, irq_id=3, irq_vector=0x1E0.
- Acknowledge: ack with epc_in=0x400 -> EPC=0x400, STATUS[1]=1, irq_req=0. Then eret -> EXL=0, epc_out=0x400.
- Priority: lines 5 and 2 both active -> irq_id=2; mtc0 IM=8'h20 before ack -> request withdrawn, re-raised with irq_id=5.
- Edge line 0 (EDGE_MASK=1): 1-cycle pulse -> IP[0] sticky. Write CAUSE 0x100 -> IP[0]=0. W1C coincident with a new edge -> IP[0] stays 1.
- CP0_TIMER_EN: COUNT=0xFFFFFFFE, COMPARE=1 -> COUNT wraps to 0, TI set when COUNT reaches 1, request on line 7; COMPARE write clears TI.
